// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run-control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam logic [15:0] HALT_OPCODE_DEF = 16'hF000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on clr, increments on inc, sticks at all-ones.
// Latency: q updates on the rising edge after clr/inc are sampled.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst (async active-low), clr, inc -> q[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run supervisor: start pulse -> RUN until halt/watchdog -> DRAIN -> DUMP handshake -> DONE.
// Latency: running rises one edge after start; dump_req DRAIN_CYCLES edges after the halt edge.
// Backpressure: DUMP holds dump_req until dump_ack; start is ignored outside IDLE/DONE.
// Ports: clk, rst (async active-low), start, mem_valid, mem_instr, dump_ack ->
//        running, dump_req, done, timed_out, cycle_count, retired_count.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                 INSTR_W      = 16,
  parameter logic [INSTR_W-1:0] HALT_OPCODE  = INSTR_W'(HALT_OPCODE_DEF),
  parameter int                 CYC_W        = 32,
  parameter int                 DRAIN_CYCLES = 1,
  parameter int                 TIMEOUT      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mem_valid,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               dump_ack,
  output logic               running,
  output logic               dump_req,
  output logic               done,
  output logic               timed_out,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [CYC_W-1:0]   retired_count
);

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
  localparam bit            HAS_DRAIN  = (DRAIN_CYCLES > 0);
  // Watchdog compares the pre-increment count, so the limit is TIMEOUT-1.
  localparam logic [CYC_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? CYC_W'(TIMEOUT - 1) : '0;
  localparam bit               WD_EN    = (TIMEOUT > 0);

  run_state_t    state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          timed_nxt;
  logic          is_halt;
  logic          wd_hit;
  logic          clr_cnt;
  logic          in_run;

  assign in_run  = (state == RUN);
  assign is_halt = mem_valid && (mem_instr == HALT_OPCODE);
  assign wd_hit  = WD_EN && (cycle_count == WD_LIMIT);
  assign clr_cnt = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      timed_out <= timed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    timed_nxt = timed_out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          timed_nxt = 1'b0;
        end
      end
      RUN: begin
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (is_halt) begin
          if (HAS_DRAIN) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_LOAD;
          end else begin
            state_nxt = DUMP;
          end
        end else if (wd_hit) begin
          state_nxt = DUMP;
          timed_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = DUMP;
        end else begin
          drain_nxt = drain_cnt - DW'(1);
        end
      end
      DUMP: begin
        if (dump_ack) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running  = (state == RUN) || (state == DRAIN);
  assign dump_req = (state == DUMP);
  assign done     = (state == DONE);

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (in_run),
    .q   (cycle_count)
  );

  sat_counter #(.W(CYC_W)) u_retired_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (in_run && mem_valid && (mem_instr != HALT_OPCODE)),
    .q   (retired_count)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances share stimulus (D=1; D=0 with TIMEOUT=8; D=1 with 4-bit counters).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_valid;
  logic [15:0] mem_instr;
  logic        dump_ack;

  logic        running_a, dump_req_a, done_a, timed_out_a;
  logic [31:0] cyc_a, ret_a;
  logic        running_b, dump_req_b, done_b, timed_out_b;
  logic [31:0] cyc_b, ret_b;
  logic        running_c, dump_req_c, done_c, timed_out_c;
  logic [3:0]  cyc_c, ret_c;

  int n_vec = 0;
  int n_err = 0;

  run_ctrl #(.CYC_W(32), .DRAIN_CYCLES(1), .TIMEOUT(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .dump_ack(dump_ack), .running(running_a), .dump_req(dump_req_a), .done(done_a),
    .timed_out(timed_out_a), .cycle_count(cyc_a), .retired_count(ret_a)
  );

  run_ctrl #(.CYC_W(32), .DRAIN_CYCLES(0), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .dump_ack(dump_ack), .running(running_b), .dump_req(dump_req_b), .done(done_b),
    .timed_out(timed_out_b), .cycle_count(cyc_b), .retired_count(ret_b)
  );

  run_ctrl #(.CYC_W(4), .DRAIN_CYCLES(1), .TIMEOUT(0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .dump_ack(dump_ack), .running(running_c), .dump_req(dump_req_c), .done(done_c),
    .timed_out(timed_out_c), .cycle_count(cyc_c), .retired_count(ret_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] instr;
    logic        ack;
    logic [3:0]  flags;   // {running, dump_req, done, timed_out}
    logic [15:0] cyc;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic v, input logic [15:0] i, input logic a,
                     input logic [3:0] f, input logic [15:0] c, input logic [15:0] r);
    vec_t t;
    t.start = s; t.valid = v; t.instr = i; t.ack = a;
    t.flags = f; t.cyc = c; t.ret = r;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mem_valid = 1'b0; mem_instr = 16'h0000; dump_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [63:0] fl_a();
    return {60'd0, running_a, dump_req_a, done_a, timed_out_a};
  endfunction
  function automatic logic [63:0] fl_b();
    return {60'd0, running_b, dump_req_b, done_b, timed_out_b};
  endfunction
  function automatic logic [63:0] fl_c();
    return {60'd0, running_c, dump_req_c, done_c, timed_out_c};
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_flags", fl_a(), 64'h0);
    chk("reset_counts", {cyc_a, ret_a}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("idle_after_reset", fl_a(), 64'h0);

    // ---- table: basic run (D=1), DRAIN ignores instr, start in DUMP, stray ack, restart ----
    add(1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'd0, 16'd0);
    for (int i = 1; i <= 5; i++)
      add(1'b0, 1'b1, 16'h1000 | 16'(i), 1'b0, 4'b1000, 16'(i), 16'(i));
    add(1'b0, 1'b1, 16'hF000, 1'b0, 4'b1000, 16'd6, 16'd5);  // halt -> DRAIN
    add(1'b0, 1'b1, 16'h1234, 1'b0, 4'b0100, 16'd6, 16'd5);  // DRAIN -> DUMP
    add(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0100, 16'd6, 16'd5);  // start ignored in DUMP
    add(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0010, 16'd6, 16'd5);  // ack -> DONE
    add(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0010, 16'd6, 16'd5);  // ack in DONE: no effect
    add(1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'd0, 16'd0);  // restart clears counters
    add(1'b0, 1'b1, 16'h2222, 1'b0, 4'b1000, 16'd1, 16'd1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'd2, 16'd1);
    add(1'b0, 1'b1, 16'hF000, 1'b0, 4'b1000, 16'd3, 16'd1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 4'b0100, 16'd3, 16'd1);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0010, 16'd3, 16'd1);

    foreach (tbl[k]) begin
      start = tbl[k].start; mem_valid = tbl[k].valid;
      mem_instr = tbl[k].instr; dump_ack = tbl[k].ack;
      step();
      chk($sformatf("table_%0d", k), {fl_a()[3:0], cyc_a[15:0], ret_a[15:0]},
          {28'd0, tbl[k].flags, tbl[k].cyc, tbl[k].ret});
    end
    idle_inputs();

    // ---- bubbles with D=0 (dut_b) ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_valid = (i % 2 == 0); mem_instr = 16'h0100 | 16'(i);
      step();
    end
    chk("bubble_pre_halt", fl_b(), 64'h8);
    mem_valid = 1'b1; mem_instr = 16'hF000;
    step();
    mem_valid = 1'b0;
    chk("d0_dump_after_halt_edge", fl_b(), 64'h4);
    chk("bubble_counts", {cyc_b, ret_b}, {32'd6, 32'd3});
    dump_ack = 1'b1; step(); dump_ack = 1'b0;
    chk("d0_done", fl_b(), 64'h2);

    // ---- watchdog, no halt (dut_b, TIMEOUT=8) ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    chk("wd_cycle7_running", {fl_b()[3:0], cyc_b}, {4'b1000, 32'd7});
    step();
    chk("wd_fires_cycle8", {fl_b()[3:0], cyc_b}, {4'b0101, 32'd8});
    dump_ack = 1'b1; step(); dump_ack = 1'b0;
    chk("wd_done_timed_out", {fl_b()[3:0], cyc_b}, {4'b0011, 32'd8});

    // ---- halt on the exact watchdog cycle: halt wins ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    mem_valid = 1'b1; mem_instr = 16'h0300;
    repeat (7) step();
    mem_instr = 16'hF000;
    step();
    mem_valid = 1'b0;
    chk("halt_beats_wd", fl_b(), 64'h4);
    dump_ack = 1'b1; step(); dump_ack = 1'b0;
    chk("halt_beats_wd_done", {fl_b()[3:0], cyc_b, ret_b}, {4'b0010, 32'd8, 32'd7});

    // ---- ack pulse in RUN ignored; ack already high when dump_req rises (dut_a) ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    mem_valid = 1'b1; mem_instr = 16'h0400; dump_ack = 1'b1;
    step();
    dump_ack = 1'b0;
    chk("ack_in_run_ignored", {fl_a()[3:0], ret_a}, {4'b1000, 32'd1});
    mem_instr = 16'hF000;
    step();
    mem_valid = 1'b0; dump_ack = 1'b1;
    chk("early_ack_in_drain", fl_a(), 64'h8);
    step();
    chk("early_ack_dump_req", fl_a(), 64'h4);
    step();
    dump_ack = 1'b0;
    chk("early_ack_one_dump_cycle", fl_a(), 64'h2);

    // ---- reset mid-DRAIN aborts with no dump ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    mem_valid = 1'b1; mem_instr = 16'h0500; step();
    mem_instr = 16'hF000; step();
    mem_valid = 1'b0;
    chk("in_drain_before_reset", fl_a(), 64'h8);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_flags", fl_a(), 64'h0);
    chk("async_reset_counts", {cyc_a, ret_a}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("held_reset_%0d", i), fl_a(), 64'h0);
    end
    rst = 1'b1;
    step();
    chk("idle_after_abort", fl_a(), 64'h0);

    // ---- saturation with 4-bit counters (dut_c) ----
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    mem_valid = 1'b1; mem_instr = 16'h0600;
    repeat (15) step();
    chk("sat_reach_max", {cyc_c, ret_c}, {56'd0, 4'd15, 4'd15});
    repeat (5) step();
    chk("sat_no_wrap", {cyc_c, ret_c}, {56'd0, 4'd15, 4'd15});
    mem_instr = 16'hF000;
    step();
    mem_valid = 1'b0;
    chk("sat_after_halt", {fl_c()[3:0], cyc_c}, {56'd0, 4'b1000, 4'd15});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
